// File: rtl/data_mem_responder.sv
// Multi-cycle word data memory for the CPU MEM stage: req/ready accept, ack after LATENCY cycles, stall while busy.
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_next;

  logic               r_we;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_idle;
  logic               w_resp;
  logic               w_accept;
  logic               w_enter_resp;
  logic               w_commit;
  logic               w_acc_we;
  logic [IDX_W-1:0]   w_acc_idx;
  logic               w_acc_misalign;
  logic               w_resp_err;
  logic               w_unused_addr;

  // Address bits above the array alias away; the low byte-offset bits only matter for the misalign check.
  assign w_unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  assign w_idle   = (r_state == S_IDLE);
  assign w_resp   = (r_state == S_RESP);
  assign w_accept = rst_i & w_idle & req_i;

  assign ready_o  = rst_i & w_idle;
  assign stall_o  = rst_i & ((w_idle & req_i) | (r_state == S_WAIT));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_next = S_RESP;
            w_cnt_next   = 4'd0;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we    <= we_i;
        r_idx   <= addr_i[IDX_W+1:2];
        r_wdata <= wdata_i;
      end
    end
  end

  // With LATENCY==1 the read happens on the accept edge, before the request fields are latched.
  assign w_enter_resp = (w_state_next == S_RESP) & ~w_resp;
  assign w_acc_we     = w_idle ? we_i : r_we;
  assign w_acc_idx    = w_idle ? addr_i[IDX_W+1:2] : r_idx;

`ifdef DMEM_MISALIGN_CHECK_EN
  logic r_misalign;
  logic r_err;

  assign w_acc_misalign = w_idle ? (addr_i[1:0] != 2'b00) : r_misalign;
  assign w_resp_err     = r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_misalign <= (addr_i[1:0] != 2'b00);
      end
      r_err <= w_enter_resp & w_acc_misalign;
    end
  end
`else
  assign w_acc_misalign = 1'b0;
  assign w_resp_err     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
    end else if (w_enter_resp && !w_acc_we && !w_acc_misalign) begin
      r_rdata <= r_mem[w_acc_idx];
    end else begin
      r_rdata <= '0;
    end
  end

  // Stores commit on the edge leaving RESP, so a read of the same word accepted next sees the new data.
  assign w_commit = rst_i & w_resp & r_we & ~w_resp_err;

  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign ack_o   = rst_i & w_resp;
  assign rdata_o = r_rdata & {32{rst_i}};
  assign err_o   = rst_i & w_resp & w_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance 0 uses LATENCY=2, instance 1 uses LATENCY=1.
module tb_data_mem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        err   [2];

  int          lat [2] = '{LAT0, LAT1};
  int          last_acc [2];
  logic [31:0] model [2][256];
  exp_t        sb [2][$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .stall_o(stall[0]), .err_o(err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .stall_o(stall[1]), .err_o(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one request and follow it to its RESP cycle; returns just after the edge leaving RESP.
  task automatic issue(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit chk_space);
    int          n;
    int          t;
    bit          mis;
    logic [7:0]  wi;
    exp_t        e;
    req[s]   = 1'b1;
    we[s]    = w;
    addr[s]  = a;
    wdata[s] = d;
    n = 0;
    @(negedge clk);
    while (ready[s] !== 1'b1) begin
      n++;
      if (n > 20) begin
        chk("accept_timeout", 32'd0, 32'd1);
        req[s] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    t = cyc;
    chk("stall_accept", stall[s], 1);
    if (chk_space) chk("accept_spacing", t - last_acc[s], lat[s] + 1);
    last_acc[s] = t;
    mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    wi      = a[9:2];
    e.err   = mis;
    e.cyc   = t + lat[s];
    e.rdata = (w || mis) ? 32'd0 : model[s][wi];
    if (w && !mis) model[s][wi] = d;
    sb[s].push_back(e);
    for (int k = 1; k <= lat[s]; k++) begin
      @(negedge clk);
      chk("ready_busy", ready[s], 0);
      chk((k < lat[s]) ? "stall_wait" : "stall_resp", stall[s], (k < lat[s]) ? 1 : 0);
      chk("ack_timing", ack[s], (k == lat[s]) ? 1 : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int s, input int n);
    req[s] = 1'b0;
    @(negedge clk);
    chk("ready_idle", ready[s], 1);
    chk("stall_idle", stall[s], 0);
    @(posedge clk); #1;
    repeat (n - 1) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard consumer: every ack pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (ack[s] === 1'b1) begin
        if (sb[s].size() == 0) begin
          chk($sformatf("unexpected_ack%0d", s), 1, 0);
        end else begin
          e = sb[s].pop_front();
          $display("[TB] inst%0d ack cycle %0d rdata=%h err=%b", s, cyc, rdata[s], err[s]);
          chk("ack_cycle", cyc, e.cyc);
          chk("rdata", rdata[s], e.rdata);
          chk("err", err[s], e.err);
        end
      end else begin
        chk("rdata_idle", rdata[s], 0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b0; req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
      last_acc[s] = 0;
    end
    req[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready[0], 0);
    chk("rst_stall", stall[0], 0);
    chk("rst_ack", ack[0], 0);
    chk("rst_rdata", rdata[0], 0);
    chk("rst_err", err[0], 0);
    @(posedge clk); #1;
    rst[0] = 1'b1; rst[1] = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    chk("ready_release0", ready[0], 1);
    chk("ready_release1", ready[1], 1);
    @(posedge clk); #1;

    // Store then load with req held: accepts 3 cycles apart.
    issue(0, 1, 32'h10, 32'hDEADBEEF, 0);
    issue(0, 0, 32'h10, 32'h0, 1);
    idle(0, 2);

    // Address aliasing modulo 1 KiB.
    issue(0, 1, 32'h400, 32'h12345678, 0);
    idle(0, 1);
    issue(0, 0, 32'h000, 32'h0, 0);
    idle(0, 1);

    // Four alternating requests with req held high throughout.
    issue(0, 1, 32'h40, 32'hA5A50001, 0);
    issue(0, 0, 32'h40, 32'h0, 1);
    issue(0, 1, 32'h44, 32'h5A5A0002, 1);
    issue(0, 0, 32'h44, 32'h0, 1);
    idle(0, 1);

    // Misaligned store followed by aligned load of the same word.
    issue(0, 1, 32'h20, 32'h11112222, 0);
    issue(0, 1, 32'h22, 32'h33334444, 1);
    issue(0, 0, 32'h20, 32'h0, 1);
    idle(0, 1);

    // Reset during WAIT aborts a store.
    issue(0, 1, 32'h30, 32'h55555555, 0);
    idle(0, 1);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hAAAAAAAA;
    n = 0;
    @(negedge clk);
    while (ready[0] !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("abort_accept", ready[0], 1);
    @(posedge clk); #1;
    rst[0] = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk("abort_ack", ack[0], 0);
    chk("abort_stall", stall[0], 0);
    chk("abort_ready", ready[0], 0);
    chk("abort_rdata", rdata[0], 0);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", ready[0], 1);
    chk("abort_stall_after", stall[0], 0);
    chk("abort_no_ack", ack[0], 0);
    @(posedge clk); #1;
    issue(0, 0, 32'h30, 32'h0, 0);
    idle(0, 1);

    // Random mix over 16 pre-written words.
    for (int i = 0; i < 16; i++) begin
      issue(0, 1, 32'h100 + 32'(i * 4), $urandom, (i != 0));
    end
    idle(0, 1);
    for (int i = 0; i < 16; i++) begin
      gap = $urandom_range(0, 2);
      issue(0, bit'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15) * 4), $urandom, 0);
      if (gap != 0) idle(0, gap);
    end
    idle(0, 1);

    // LATENCY=1 instance: ack the cycle after accept, ready again one cycle later.
    issue(1, 1, 32'h8, 32'hCAFEF00D, 0);
    issue(1, 0, 32'h8, 32'h0, 1);
    idle(1, 1);
    issue(1, 1, 32'h40C, 32'h0BADF00D, 0);
    issue(1, 0, 32'h00C, 32'h0, 1);
    idle(1, 2);

    repeat (4) @(posedge clk);
    chk("sb_empty0", sb[0].size(), 0);
    chk("sb_empty1", sb[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data memory responder that serves the load/store port of the pipelined CPU's MEM stage. It accepts one word request at a time over a req/ready handshake. After a programmable latency it returns read data with a one-cycle ack pulse. While a request is outstanding it drives a stall to freeze the pipeline. It replaces the single-cycle data memory and lets the CPU run against slow backing storage.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 4..4096.
- LATENCY, 2: cycles from the accept cycle to the ack cycle; 1..15.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- req_i  input  1  request valid; must stay high with stable fields until accepted.
- we_i  input  1  1 = store, 0 = load.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data.
- ready_o  output  1  high only in IDLE with rst_i high; a request is accepted in a cycle where req_i & ready_o.
- ack_o  output  1  one-cycle completion pulse.
- rdata_o  output  32  load data; valid only while ack_o is high, otherwise 0.
- stall_o  output  1  pipeline freeze request.
- err_o  output  1  misaligned-access flag, qualified by ack_o.

## Operation
- **States**
  - IDLE
    - Go to WAIT on accept.
    - If LATENCY == 1, go directly to RESP instead.
  - WAIT
    - Down-counter `cnt` (4 bits) is loaded with LATENCY-1 on accept.
    - `cnt` decrements each cycle.
    - When `cnt` == 1, go to RESP.
  - RESP
    - ack_o = 1 for exactly one cycle.
    - Always returns to IDLE.
- **Accept**
  - On accept, latch we_i, addr_i and wdata_i into internal registers.
  - Inputs are ignored after the accept edge.
- **Index**
  - idx = addr_q[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- **Load**
  - The array word at idx is registered into rdata_o on the edge entering RESP.
  - rdata_o returns to 0 on the edge leaving RESP.
- **Store**
  - The array word at idx is written with wdata_q on the edge leaving RESP.
  - rdata_o = 0 during a store's RESP cycle.
- **stall_o** = (IDLE & req_i) | WAIT, with rst_i high.
  - Low in the RESP cycle, so the MEM stage advances on the same edge that completes the access.
- **Back-to-back**
  - A new request can be accepted no earlier than the cycle after RESP.
  - Minimum spacing between accepts is LATENCY+1 cycles.
- **Read-after-write** to the same word always returns the new data, because the write commits before the next accept.
- **Reset (rst_i low at an edge)**
  - State returns to IDLE and `cnt` clears to 0.
  - Latched request fields clear; any outstanding access is aborted and no write occurs.
  - Array contents are not reset.
- **Outputs while rst_i is low:** ready_o = 0, ack_o = 0, rdata_o = 0, stall_o = 0, err_o = 0.
- **After reset release:** ready_o = 1 in the first cycle with rst_i high.

## Timing
- Accept in cycle t → ack_o high in cycle t+LATENCY.
- ready_o high again in cycle t+LATENCY+1.
- ready_o and stall_o are combinational from state and req_i; all other outputs are registered.
- req_i dropped before accept: no effect.
- req_i dropped after accept: the access still completes.
- req_i held high through RESP: treated as a new request and accepted in the cycle after RESP.

## Configuration
- **DMEM_MISALIGN_CHECK_EN defined**
  - An access with addr_i[1:0] != 0 still completes with normal latency.
  - ack_o = 1, err_o = 1, rdata_o = 0.
  - A misaligned store does not modify the array.
- **DMEM_MISALIGN_CHECK_EN undefined**
  - addr_i[1:0] is ignored and the word is accessed normally.
  - err_o is tied to 0.

## Test plan
- LATENCY=2: store 0xDEADBEEF to 0x10 accepted at t → ack at t+2, err_o = 0. Load 0x10 accepted at t+3 → ack at t+5 with rdata_o = 0xDEADBEEF; stall_o high in t+3..t+4 only.
- DEPTH_WORDS=256: store 0x12345678 to 0x400, then load 0x000 → rdata_o = 0x12345678 (wrap alias).
- req_i held high across four alternating stores/loads → accepts spaced exactly LATENCY+1 cycles apart; each load returns the prior store's data.
- LATENCY=1: load accepted at t → ack and data at t+1, ready_o high at t+2.
- rst_i low in the WAIT cycle of a store of 0xAAAAAAAA over an existing 0x55555555 → no ack. Next cycle ready_o = 1, stall_o = 0; a subsequent load returns 0x55555555.
- With DMEM_MISALIGN_CHECK_EN: store to 0x22 → ack with err_o = 1; load 0x20 returns the unchanged value. Without the macro: store to 0x22 → err_o = 0; load 0x20 returns the stored data.
